adder_serial_ctrl: RTL and testbench
====================================

// Module: adder_serial_ctrl
// PURPOSE
//  - Sequencer that computes a wide (8*NBYTES-bit) unsigned add on one shared 8-bit adder_gate.
//  - adder_gate has no carry-in, so each byte takes two adder passes:
//      - ADD pass: x_i + y_i.
//      - CARRY pass: partial sum + incoming carry.
//  - Sits between a requesting datapath (start/done handshake) and the 8-bit adder resource.
// PARAMETERS
//  - NBYTES  default 4  operand width in bytes (>=1); operand width W = 8*NBYTES
// PORTS
//  - clk    in   1  system clock, rising edge
//  - rst_n  in   1  asynchronous active-low reset
//  - start  in   1  request; sampled only in IDLE
//  - a      in   W  operand A; latched on the accepted start edge
//  - b      in   W  operand B; latched on the accepted start edge
//  - busy   out  1  high while an operation is in flight
//  - done   out  1  one-cycle pulse; sum/cout valid from this cycle on
//  - sum    out  W  result a+b mod 2^W; held until the next completion
//  - cout   out  1  carry out of the MSB byte; held like sum
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//      - state=IDLE; busy=0, done=0, sum=0, cout=0.
//      - All internal registers cleared: idx, cin, partial, work, latched operands.
//      - Takes effect immediately, including mid-operation; the in-flight op is discarded, no done.
//  - FSM states: IDLE, ADD, CARRY.
//      - IDLE -> ADD on start=1.
//          - Latch a/b; idx<=0; cin<=0; busy<=1.
//      - ADD -> CARRY, unconditional.
//          - Adder inputs x=a[idx], y=b[idx].
//          - Register partial<=out and c1<=carry.
//      - CARRY -> ADD or IDLE.
//          - Adder inputs x=partial, y={7'b0,cin}.
//          - work[idx]<=out; cin<=c1|carry. c1 and the pass-2 carry are never both 1.
//          - If idx==NBYTES-1 -> IDLE:
//              - sum<=completed work; cout<=c1|carry.
//              - done<=1; busy<=0.
//          - Else idx<=idx+1 -> ADD.
//  - Adder input mux is purely a function of state/idx. In IDLE, drive x=y=0.
//  - Latency:
//      - Start accepted at edge E0.
//      - Result registered at edge E(2*NBYTES); done high for exactly the following cycle.
//      - NBYTES=4: 8 cycles. Fixed; no data-dependent early exit.
//  - busy: high from E0 through E(2*NBYTES), low in the done cycle.
//  - start while busy: ignored. No queueing, no effect on the in-flight op.
//  - start in the done cycle: accepted (state is IDLE). Back-to-back throughput is one op per 2*NBYTES cycles.
//  - done is registered and deasserts on the next edge unless a new op completes.
//  - sum/cout change only on a completion edge or on reset, never mid-operation.
//  - Width rules:
//      - idx is clog2(NBYTES) bits, minimum 1.
//      - Byte i = bits [8i+7:8i]; byte 0 (LSB) is processed first.
// STRUCTURE
//  - Shared include adder_defs.vh holds:
//      - BYTE_W=8.
//      - FSM state encodings S_IDLE/S_ADD/S_CARRY (2-bit).
//      - Default NBYTES.
//  - Exactly one sub-module instance: adder_gate u_add (x, y, carry, out), the shared 8-bit resource.
//  - Everything else is local: FSM, idx counter, cin/c1 flops, partial register, work register.
// TESTING
//  1. a=0x000000FF, b=0x00000001 -> sum=0x00000100, cout=0. done exactly 8 cycles after start; busy high 8 cycles.
//  2. a=0xFFFFFFFF, b=0x00000001 -> sum=0x00000000, cout=1. Carry ripples through all 4 CARRY passes.
//  3. a=0x12345678, b=0x87654321 -> sum=0x99999999, cout=0.
//     Then a=0x80000000, b=0x80000000 -> sum=0, cout=1.
//  4. start with a=1,b=2; pulse start again at cycle 3 with a=b=0xFF -> single done, sum=0x00000003; second request dropped.
//  5. rst_n=0 at cycle 4 of an op -> busy/done/sum/cout go 0 asynchronously.
//     After release, a=5,b=7 -> sum=0x0000000C after 8 cycles.
//  6. Back-to-back: start held high through the done cycle -> second op accepted there. Second done exactly 8 cycles later.
//     Random 200-op sweep vs {cout,sum}=a+b golden, zero mismatches.

Source files
------------

// File: rtl/adder_serial_ctrl_pkg.sv
// Shared definitions for the byte-serial wide adder: byte width, default size, FSM states.
package adder_serial_ctrl_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned DEF_NBYTES = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_CARRY = 2'd2
    } state_e;

endpackage

// File: rtl/adder_serial_ctrl_if.sv
// Start/done request bus between the requesting datapath and the serial adder.
interface adder_serial_ctrl_if #(
    parameter int unsigned NBYTES = adder_serial_ctrl_pkg::DEF_NBYTES
);
    localparam int unsigned W = 8 * NBYTES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    modport master (output start, a, b, input busy, done, sum, cout);
    modport slave  (input start, a, b, output busy, done, sum, cout);

endinterface

// File: rtl/adder_serial_ctrl_gate.sv
// Shared 8-bit adder resource; no carry-in, so carries are folded in by a second pass.
module adder_gate
    import adder_serial_ctrl_pkg::*;
(
    input  logic [BYTE_W-1:0] x,
    input  logic [BYTE_W-1:0] y,
    output logic              carry,
    output logic [BYTE_W-1:0] out
);

    assign {carry, out} = x + y;

endmodule

// File: rtl/adder_serial_ctrl.sv
// Wide unsigned adder sequenced over one 8-bit adder_gate: per byte an ADD pass then a CARRY pass.
module adder_serial_ctrl
    import adder_serial_ctrl_pkg::*;
#(
    parameter int unsigned NBYTES = DEF_NBYTES
) (
    input  logic               clk,
    input  logic               rst_n,
    adder_serial_ctrl_if.slave bus
);

    localparam int unsigned W     = 8 * NBYTES;
    localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_e              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic                cin_q;
    logic                c1_q;
    logic [BYTE_W-1:0]   partial_q;
    logic [W-1:0]        work_q;
    logic [W-1:0]        work_d;
    logic [W-1:0]        a_q;
    logic [W-1:0]        b_q;
    logic                busy_q;
    logic                done_q;
    logic [W-1:0]        sum_q;
    logic                cout_q;

    logic [BYTE_W-1:0]   add_x;
    logic [BYTE_W-1:0]   add_y;
    logic [BYTE_W-1:0]   add_out;
    logic                add_carry;

    adder_gate u_add (
        .x     (add_x),
        .y     (add_y),
        .carry (add_carry),
        .out   (add_out)
    );

    always_comb begin
        add_x  = '0;
        add_y  = '0;
        work_d = work_q;
        unique case (state_q)
            S_ADD: begin
                add_x = a_q[{idx_q, 3'b000} +: BYTE_W];
                add_y = b_q[{idx_q, 3'b000} +: BYTE_W];
            end
            S_CARRY: begin
                add_x = partial_q;
                add_y = {{(BYTE_W-1){1'b0}}, cin_q};
                work_d[{idx_q, 3'b000} +: BYTE_W] = add_out;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cin_q     <= 1'b0;
            c1_q      <= 1'b0;
            partial_q <= '0;
            work_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        idx_q   <= '0;
                        cin_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_ADD;
                    end
                end
                S_ADD: begin
                    partial_q <= add_out;
                    c1_q      <= add_carry;
                    state_q   <= S_CARRY;
                end
                S_CARRY: begin
                    // c1 and the carry-pass carry are mutually exclusive, so OR is the byte carry-out
                    work_q <= work_d;
                    cin_q  <= c1_q | add_carry;
                    if (idx_q == LAST_IDX) begin
                        sum_q   <= work_d;
                        cout_q  <= c1_q | add_carry;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        idx_q   <= idx_q + IDX_W'(1);
                        state_q <= S_ADD;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_adder_serial_ctrl.sv
// Directed and randomised checks of the byte-serial wide adder at NBYTES=4.
module tb_adder_serial_ctrl;

    localparam int unsigned NB = 4;
    localparam int unsigned LAT = 2 * NB;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    adder_serial_ctrl_if #(.NBYTES(NB)) bus ();

    adder_serial_ctrl #(.NBYTES(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one request, waits for done, checks latency, busy span and result.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_sum, input logic exp_cout);
        int cycles;
        int busy_cnt;
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cycles    = 0;
        busy_cnt  = bus.busy ? 1 : 0;
        while (!bus.done && cycles < 3 * LAT) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus.busy) busy_cnt++;
        end
        check({tag, "_lat"},  64'(cycles), 64'(LAT));
        check({tag, "_busy"}, 64'(busy_cnt), 64'(LAT));
        check({tag, "_busyd"}, 64'(bus.busy), 64'(0));
        check({tag, "_sum"},  64'(bus.sum), 64'(exp_sum));
        check({tag, "_cout"}, 64'(bus.cout), 64'(exp_cout));
    endtask

    initial begin
        int cycles;
        int dones;
        logic [31:0] ra, rb;
        logic [32:0] gold;

        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_sum",  64'(bus.sum),  64'(0));
        check("rst_cout", 64'(bus.cout), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_op("t1", 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0);
        @(posedge clk);
        #1;
        check("t1_done_pulse", 64'(bus.done), 64'(0));
        check("t1_sum_hold",   64'(bus.sum),  64'h100);
        run_op("t2", 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
        run_op("t3a", 32'h1234_5678, 32'h8765_4321, 32'h9999_9999, 1'b0);
        run_op("t3b", 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1);

        // Second request mid-operation must be dropped.
        @(negedge clk);
        bus.a = 32'd1; bus.b = 32'd2; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.a = 32'hFF; bus.b = 32'hFF; bus.start = 1'b1;
        check("t4_sum_stable", 64'(bus.sum), 64'(0));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cycles = 3;
        while (!bus.done && cycles < 3 * LAT) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("t4_lat", 64'(cycles), 64'(LAT));
        check("t4_sum", 64'(bus.sum), 64'h3);
        dones = 0;
        repeat (3 * LAT) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        check("t4_no_second", 64'(dones), 64'(0));
        check("t4_idle_busy", 64'(bus.busy), 64'(0));

        // Asynchronous reset mid-operation.
        @(negedge clk);
        bus.a = 32'hFFFF_FFFF; bus.b = 32'h1; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_busy", 64'(bus.busy), 64'(0));
        check("t5_done", 64'(bus.done), 64'(0));
        check("t5_sum",  64'(bus.sum),  64'(0));
        check("t5_cout", 64'(bus.cout), 64'(0));
        dones = 0;
        repeat (2 * LAT) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        check("t5_no_done", 64'(dones), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_op("t5r", 32'd5, 32'd7, 32'h0000_000C, 1'b0);

        // Back-to-back: start held high, second op accepted in the done cycle.
        @(negedge clk);
        bus.a = 32'h0000_0010; bus.b = 32'h0000_0020; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.a = 32'hF000_0000; bus.b = 32'h1000_0001;
        cycles = 0;
        while (!bus.done && cycles < 3 * LAT) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("t6a_lat", 64'(cycles), 64'(LAT));
        check("t6a_sum", 64'(bus.sum), 64'h30);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("t6_accept_busy", 64'(bus.busy), 64'(1));
        cycles = 0;
        while (!bus.done && cycles < 3 * LAT) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("t6b_lat",  64'(cycles), 64'(LAT));
        check("t6b_sum",  64'(bus.sum), 64'h0000_0001);
        check("t6b_cout", 64'(bus.cout), 64'(1));

        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rb = $urandom;
            gold = {1'b0, ra} + {1'b0, rb};
            run_op("rnd", ra, rb, gold[31:0], gold[32]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
